// File: rtl/de_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : de_reg_scoreboard
// Brief    : Decode-stage register hazard scoreboard. It keeps a pending-write
//            count per GPR, stalls DE on reads of pending registers and caps
//            the total number of writes in flight.
//            Optional CSR hazard tracking is enabled with DE_SCOREBOARD_CSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module de_reg_scoreboard #(
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2,
    parameter int MAX_INFLT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_wr_reg,
    input  logic [REGNOBITS-1:0] issue_rd,
    input  logic                 rs1_read,
    input  logic [REGNOBITS-1:0] rs1,
    input  logic                 rs2_read,
    input  logic [REGNOBITS-1:0] rs2,
    input  logic                 flush,
    input  logic                 retire_valid,
    input  logic                 retire_wr_reg,
    input  logic [REGNOBITS-1:0] retire_rd,
`ifdef DE_SCOREBOARD_CSR_EN
    input  logic                 issue_wr_csr,
    input  logic                 csr_read,
    input  logic                 retire_wr_csr,
`endif
    output logic                 stall_out,
    output logic                 issue_fire,
    output logic [CNTBITS+2:0]   inflight_cnt,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam int                     c_nregs     = 2**REGNOBITS;
    localparam int                     c_ifw       = CNTBITS + 3;
    localparam logic [CNTBITS-1:0]     c_cnt_max   = '1;
    localparam logic [CNTBITS-1:0]     c_cnt_one   = CNTBITS'(1);
    localparam logic [c_ifw-1:0]       c_ifl_one   = c_ifw'(1);
    localparam logic [c_ifw-1:0]       c_max_inflt = c_ifw'(MAX_INFLT);
    localparam logic [REGNOBITS-1:0]   c_x0        = '0;

    logic [c_nregs-1:0][CNTBITS-1:0] r_cnt;
    logic [c_ifw-1:0]                r_inflight;
    logic                            r_err_ovf;
    logic                            r_err_unf;

    logic                 w_ret_any;
    logic                 w_rs1_hit;
    logic                 w_rs2_hit;
    logic [CNTBITS-1:0]   w_rs1_net;
    logic [CNTBITS-1:0]   w_rs2_net;
    logic                 w_rs1_stall;
    logic                 w_rs2_stall;
    logic [c_ifw-1:0]     w_inflt_net;
    logic                 w_wr_stall;
    logic                 w_csr_stall;
    logic                 w_stall;
    logic                 w_fire;
    logic                 w_iss_cnt;
    logic                 w_same_reg;
    logic [CNTBITS-1:0]   w_iss_reg_cnt;
    logic [CNTBITS-1:0]   w_ret_reg_cnt;
    logic                 w_inc_eff;
    logic                 w_dec_eff;
    logic                 w_ovf;
    logic                 w_unf;

    // Retires are qualified once; x0 is never tracked so its writes never hit.
    assign w_ret_any = retire_valid & retire_wr_reg & (retire_rd != c_x0);
    assign w_rs1_hit = w_ret_any & (retire_rd == rs1);
    assign w_rs2_hit = w_ret_any & (retire_rd == rs2);

    // WB writes the regfile on the negedge, so a same-cycle retire of the last
    // pending write makes the register readable without a stall.
    assign w_rs1_net   = r_cnt[rs1] - CNTBITS'(w_rs1_hit);
    assign w_rs2_net   = r_cnt[rs2] - CNTBITS'(w_rs2_hit);
    assign w_rs1_stall = rs1_read & (rs1 != c_x0) & (w_rs1_net != '0);
    assign w_rs2_stall = rs2_read & (rs2 != c_x0) & (w_rs2_net != '0);

    // Retires that arrive with nothing in flight must not wrap the headroom check.
    assign w_inflt_net = (w_ret_any && (r_inflight != '0)) ? (r_inflight - c_ifl_one)
                                                            : r_inflight;
    assign w_wr_stall  = issue_wr_reg & (issue_rd != c_x0) & (w_inflt_net >= c_max_inflt);

    assign w_stall = issue_valid & (w_rs1_stall | w_rs2_stall | w_wr_stall | w_csr_stall);
    assign w_fire  = issue_valid & ~w_stall & ~flush;

    assign w_iss_cnt     = w_fire & issue_wr_reg & (issue_rd != c_x0);
    assign w_same_reg    = w_iss_cnt & w_ret_any & (issue_rd == retire_rd);
    assign w_iss_reg_cnt = r_cnt[issue_rd];
    assign w_ret_reg_cnt = r_cnt[retire_rd];

    // An issue and retire on the same register cancel; otherwise each side is
    // applied unless it would saturate or underflow its counter.
    assign w_inc_eff = w_iss_cnt & ~w_same_reg & (w_iss_reg_cnt != c_cnt_max);
    assign w_ovf     = w_iss_cnt & ~w_same_reg & (w_iss_reg_cnt == c_cnt_max);
    assign w_dec_eff = w_ret_any & ~w_same_reg & (w_ret_reg_cnt != '0);
    assign w_unf     = w_ret_any & ~w_same_reg & (w_ret_reg_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_inflight <= '0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
        end else begin
            // Effective increment and decrement never target the same register.
            if (w_inc_eff) begin
                r_cnt[issue_rd] <= w_iss_reg_cnt + c_cnt_one;
            end
            if (w_dec_eff) begin
                r_cnt[retire_rd] <= w_ret_reg_cnt - c_cnt_one;
            end
            if (w_inc_eff && !w_dec_eff) begin
                r_inflight <= r_inflight + c_ifl_one;
            end else if (w_dec_eff && !w_inc_eff) begin
                r_inflight <= r_inflight - c_ifl_one;
            end
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_unf) begin
                r_err_unf <= 1'b1;
            end
        end
    end

`ifdef DE_SCOREBOARD_CSR_EN
    logic r_csr_pend;
    logic w_csr_clr;

    assign w_csr_clr   = retire_valid & retire_wr_csr;
    assign w_csr_stall = csr_read & r_csr_pend & ~w_csr_clr;

    // Set wins over clear when a CSR write issues as the previous one retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csr_pend <= 1'b0;
        end else if (w_fire && issue_wr_csr) begin
            r_csr_pend <= 1'b1;
        end else if (w_csr_clr) begin
            r_csr_pend <= 1'b0;
        end
    end
`else
    assign w_csr_stall = 1'b0;
`endif

    assign stall_out     = w_stall;
    assign issue_fire    = w_fire;
    assign inflight_cnt  = r_inflight;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule
`default_nettype wire
